// File: rtl/cic_comb_seq.sv
// CIC decimation and time-multiplexed comb section: decimates the integrator
// stream by DEC and runs STAGES combs through one shared subtractor, one per clk.
module cic_comb_seq #(
  parameter int W      = 37,
  parameter int OUT_W  = 17,
  parameter int DEC    = 5,
  parameter int STAGES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [W-1:0]     Xin,
  output logic signed [OUT_W-1:0] Yout,
  output logic                    rdy,
  output logic                    busy,
  output logic                    ovf
);

  localparam int CW = (DEC > 1) ? $clog2(DEC) : 1;
  localparam int KW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEC - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(STAGES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [KW-1:0] k;
  logic [W-1:0]  acc;
  logic [W-1:0]  dly [STAGES];
  logic [W-1:0]  t;
  logic          strobe;

  assign strobe = (cnt == CNT_LAST);

  // Shared comb subtractor; wraps modulo 2^W as CIC arithmetic requires.
  always_comb begin
    t = acc - dly[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      state <= IDLE;
      k     <= '0;
      acc   <= '0;
      for (int unsigned i = 0; i < STAGES; i++) dly[i] <= '0;
      Yout  <= '0;
      rdy   <= 1'b0;
      busy  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      cnt <= strobe ? '0 : cnt + CW'(1);
      rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (strobe) begin
            acc   <= Xin;
            k     <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          // A strobe here drops its sample; the running sequence is unaffected.
          if (strobe) ovf <= 1'b1;
          dly[k] <= acc;
          acc    <= t;
          if (k == K_LAST) begin
            Yout  <= t[W-1:W-OUT_W];
            rdy   <= 1'b1;
            state <= IDLE;
            k     <= '0;
            busy  <= 1'b0;
          end else begin
            k <= k + KW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cic_comb_seq.sv
// Scoreboard bench for cic_comb_seq: three instances (default, small comb, overrun)
// with expected outputs from a binomial-difference reference model.
module tb_cic_comb_seq;

  localparam int SG [3] = '{3, 2, 2};
  localparam int WW [3] = '{37, 8, 8};
  localparam int OW [3] = '{17, 8, 8};
  localparam int DC [3] = '{5, 4, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  logic        rst0, rst1, rst2;
  logic [36:0] x0;
  logic [7:0]  x1, x2;
  logic [16:0] y0;
  logic [7:0]  y1, y2;
  logic        rdy0, rdy1, rdy2, busy0, busy1, busy2, ovf0, ovf1, ovf2;

  cic_comb_seq d0 (.clk(clk), .rst(rst0), .Xin(x0), .Yout(y0), .rdy(rdy0), .busy(busy0), .ovf(ovf0));

  cic_comb_seq #(.W(8), .OUT_W(8), .DEC(4), .STAGES(2)) d1 (
    .clk(clk), .rst(rst1), .Xin(x1), .Yout(y1), .rdy(rdy1), .busy(busy1), .ovf(ovf1));

  cic_comb_seq #(.W(8), .OUT_W(8), .DEC(2), .STAGES(2)) d2 (
    .clk(clk), .rst(rst2), .Xin(x2), .Yout(y2), .rdy(rdy2), .busy(busy2), .ovf(ovf2));

  typedef struct {
    longint unsigned val;
    int unsigned     at;
  } exp_t;

  exp_t   q0[$], q1[$], q2[$];
  longint h [3][4];

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output of an s-stage comb with zeroed delays: sum_j (-1)^j C(s,j) x[n-j].
  function automatic longint unsigned comb_model(input longint hs[4], input int s, input int w, input int ow);
    longint          sum = 0;
    longint          c = 1;
    longint unsigned m;
    for (int j = 0; j <= s; j++) begin
      sum += ((j % 2) != 0) ? -(c * hs[j]) : c * hs[j];
      c = c * (s - j) / (j + 1);
    end
    m = (64'd1 << w) - 1;
    return ($unsigned(sum) & m) >> (w - ow);
  endfunction

  task automatic push_exp(input int id, input longint v, input int unsigned at);
    exp_t e;
    for (int j = 3; j > 0; j--) h[id][j] = h[id][j-1];
    h[id][0] = v;
    e.val = comb_model(h[id], SG[id], WW[id], OW[id]);
    e.at  = at;
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input int id);
    case (id)
      0: begin rst0 = 1'b1; x0 = '0; end
      1: begin rst1 = 1'b1; x1 = '0; end
      default: begin rst2 = 1'b1; x2 = '0; end
    endcase
    for (int j = 0; j < 4; j++) h[id][j] = 0;
    repeat (3) step();
    case (id)
      0: check("rst_state0", {y0, rdy0, busy0, ovf0}, 0);
      1: check("rst_state1", {y1, rdy1, busy1, ovf1}, 0);
      default: check("rst_state2", {y2, rdy2, busy2, ovf2}, 0);
    endcase
    case (id)
      0: rst0 = 1'b0;
      1: rst1 = 1'b0;
      default: rst2 = 1'b0;
    endcase
  endtask

  // Holds v for one decimation period so it is the sample captured at its end.
  task automatic send(input int id, input longint v, input bit push);
    case (id)
      0: x0 = 37'(v);
      default: x1 = 8'(v);
    endcase
    if (push) push_exp(id, v, cyc + DC[id] + SG[id]);
    repeat (DC[id]) step();
    case (id)
      0: check("busy0", busy0, 1);
      default: check("busy1", busy1, 1);
    endcase
  endtask

  exp_t e0, e1, e2;

  always @(negedge clk) begin
    if (rdy0) begin
      if (q0.size() == 0) check("rdy0_unexp", rdy0, 0);
      else begin e0 = q0.pop_front(); check("y0", y0, e0.val); check("t0", cyc, e0.at); end
    end else if (q0.size() != 0 && q0[0].at <= cyc) begin
      check("rdy0_miss", rdy0, 1);
      void'(q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rdy1) begin
      if (q1.size() == 0) check("rdy1_unexp", rdy1, 0);
      else begin e1 = q1.pop_front(); check("y1", y1, e1.val); check("t1", cyc, e1.at); end
    end else if (q1.size() != 0 && q1[0].at <= cyc) begin
      check("rdy1_miss", rdy1, 1);
      void'(q1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rdy2) begin
      if (q2.size() == 0) check("rdy2_unexp", rdy2, 0);
      else begin e2 = q2.pop_front(); check("y2", y2, e2.val); check("t2", cyc, e2.at); end
    end else if (q2.size() != 0 && q2[0].at <= cyc) begin
      check("rdy2_miss", rdy2, 1);
      void'(q2.pop_front());
    end
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    x0 = '0; x1 = '0; x2 = '0;
    repeat (2) step();

    // Defaults: zero input, first rdy DEC+STAGES edges after release.
    reset_dut(0);
    repeat (2) send(0, 0, 1);

    // Truncation: a 2^20 step on a settled input gives Yout = 1.
    repeat (4) send(0, 64'd12345678, 1);
    send(0, 64'd12345678 + (64'd1 << 20), 1);
    repeat (4) step();
    check("trunc_y", y0, 1);

    // Reset one edge into RUN aborts the sequence.
    reset_dut(0);
    send(0, 5, 0);
    step();
    rst0 = 1'b1;
    step();
    check("abort_state", {rdy0, busy0, d0.cnt}, 0);
    for (int j = 0; j < 4; j++) h[0][j] = 0;
    repeat (2) step();
    rst0 = 1'b0;
    repeat (3) send(0, 7, 1);
    repeat (4) step();
    rst0 = 1'b1;

    // Small comb: quadratic input gives constant second difference.
    reset_dut(1);
    send(1, 10, 1);
    send(1, 30, 1);
    send(1, 60, 1);
    send(1, 100, 1);
    repeat (3) step();
    check("comb_y", y1, 10);

    // Wrap-around with no saturation.
    reset_dut(1);
    send(1, 120, 1);
    send(1, 130, 1);
    repeat (3) step();
    check("wrap_y", y1, 8'h92);
    check("wrap_stage1", d1.dly[1], 10);
    rst1 = 1'b1;

    // Overrun: DEC=2 < STAGES+1, every other strobe lands in RUN.
    reset_dut(2);
    for (int i = 1; i <= 12; i++) begin
      x2 = 8'(7 * i + 1);
      if (i % 4 == 2) push_exp(2, 7 * i + 1, cyc + 3);
      step();
      check("ovf", ovf2, (i >= 4) ? 1 : 0);
    end
    rst2 = 1'b1;
    step();
    check("ovf_clr", ovf2, 0);

    repeat (2) step();
    check("q0_drain", q0.size(), 0);
    check("q1_drain", q1.size(), 0);
    check("q2_drain", q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
